// File: rtl/fod_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : fod_phase_monitor
//  Purpose  : Receive-side phase monitor for the FOD controller. Decodes the
//             aux-PLL multiphase sampler word into a 3-bit phase, unwraps it,
//             compares it with the phase predicted by FCW_FOD and produces a
//             signed phase error, a lock flag and a sign-sign LMS estimate
//             of the DTC gain.
//  Ports    : CLK       - FDTC-domain clock, rising edge
//             ARST      - asynchronous active-high reset
//             CAL_EN    - enable tracking / calibration
//             PSAMP     - sampler word, bit k = aux phase k
//             FCW_FOD   - unsigned WI.WF divide ratio
//             DTC_DCW   - DTC code applied on the current FDTC edge
//             PHE       - decoded phase index
//             PHE_VALID - PHE updated with a legal code this cycle
//             BUB_ERR   - one-cycle pulse on an illegal sampler code
//             ERR_CNT   - saturating count of illegal codes
//             PERR      - signed phase error
//             LOCK      - phase locked
//             KDTC      - DTC gain estimate
//  Revision : 1.0 - initial release
// ============================================================================
module fod_phase_monitor #(
   parameter int WI        = 6,
   parameter int WF        = 16,
   parameter int PW        = 12,
   parameter int KW        = 10,
   parameter int KDTC_INIT = 512,
   parameter int LOCK_THR  = 64,
   parameter int LOCK_CNT  = 63
) (
   input  logic                CLK,
   input  logic                ARST,
   input  logic                CAL_EN,
   input  logic [7:0]          PSAMP,
   input  logic [WI+WF-1:0]    FCW_FOD,
   input  logic [9:0]          DTC_DCW,
   output logic [2:0]          PHE,
   output logic                PHE_VALID,
   output logic                BUB_ERR,
   output logic [7:0]          ERR_CNT,
   output logic [PW-1:0]       PERR,
   output logic                LOCK,
   output logic [KW-1:0]       KDTC
);

   localparam int            c_A        = 3 + WF;
   localparam logic [PW-1:0] c_LOCK_THR = PW'(LOCK_THR);
   localparam logic [7:0]    c_CNT_LAST = 8'(LOCK_CNT - 1);
   localparam logic [KW-1:0] c_KMAX     = {KW{1'b1}};
   localparam logic [9:0]    c_DCW_MID  = 10'd512;

   typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_TRACK, S_LOCKED} state_t;

   // ---------------- stage 1: input register ----------------
   logic [7:0]     r_psamp;
   logic           r_s1_vld;   // blocks decoding of the reset value of r_psamp
   logic [9:0]     r_dcw1, r_dcw2, r_dcw3;

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         r_psamp  <= '0;
         r_s1_vld <= 1'b0;
         r_dcw1   <= '0;
      end else begin
         r_psamp  <= PSAMP;
         r_s1_vld <= 1'b1;
         r_dcw1   <= DTC_DCW;
      end
   end

   // ---------------- stage 2: decode ----------------
   // A clean sampler word is a ring thermometer with exactly one 1->0 edge
   // (bit k = 1, bit k+1 = 0, bit 7 wrapping to bit 0). Zero edges (00/FF)
   // or several edges (bubbles) are illegal.
   logic [7:0] w_fall;
   logic       w_legal;
   logic [2:0] w_idx;

   always_comb begin
      w_idx = 3'd0;
      for (int k = 0; k < 8; k++) begin
         w_fall[k] = r_psamp[k] & ~r_psamp[(k + 1) % 8];
      end
      for (int k = 7; k >= 0; k--) begin
         if (w_fall[k]) w_idx = 3'(k);
      end
      w_legal = (w_fall != 8'd0) && ((w_fall & (w_fall - 8'd1)) == 8'd0);
   end

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         PHE       <= '0;
         PHE_VALID <= 1'b0;
         BUB_ERR   <= 1'b0;
         ERR_CNT   <= '0;
         r_dcw2    <= '0;
      end else begin
         r_dcw2    <= r_dcw1;
         PHE_VALID <= r_s1_vld & w_legal;
         BUB_ERR   <= r_s1_vld & ~w_legal;
         if (r_s1_vld & w_legal) PHE <= w_idx;
         if (r_s1_vld & ~w_legal & (ERR_CNT != 8'hFF)) ERR_CNT <= ERR_CNT + 8'd1;
      end
   end

   // ---------------- stage 3: unwrap, expected phase, error, FSM ----------------
   state_t          r_state;
   logic [2:0]      r_phe_prev;
   logic [c_A-1:0]  r_pm, r_pe;
   logic [7:0]      r_cnt;
   logic            r_perr_upd;   // PERR was refreshed in TRACK/LOCKED

   logic [2:0]      w_dphe;
   logic [c_A-1:0]  w_pm_next, w_pe_next, w_e;
   logic [PW-1:0]   w_perr, w_perr_abs;
   logic            w_in_win;
   logic            w_unused;

   // Mod-8 phase difference scaled to accumulator units; one FDTC period is
   // 4*FCW eighth-aux-phases, truncated to the accumulator width.
   assign w_dphe     = PHE - r_phe_prev;
   assign w_pm_next  = r_pm + {w_dphe, {WF{1'b0}}};
   assign w_pe_next  = r_pe + {FCW_FOD[c_A-3:0], 2'b00};
   assign w_e        = w_pm_next - w_pe_next;
   assign w_perr     = w_e[c_A-1 -: PW];
   assign w_perr_abs = w_perr[PW-1] ? (~w_perr + 1'b1) : w_perr;
   assign w_in_win   = w_perr_abs < c_LOCK_THR;
   assign w_unused   = ^{FCW_FOD[WI+WF-1:c_A-2], w_e[c_A-PW-1:0]};

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         r_state    <= S_IDLE;
         r_phe_prev <= '0;
         r_pm       <= '0;
         r_pe       <= '0;
         r_cnt      <= '0;
         r_perr_upd <= 1'b0;
         r_dcw3     <= '0;
         PERR       <= '0;
         LOCK       <= 1'b0;
      end else begin
         r_dcw3     <= r_dcw2;
         r_perr_upd <= 1'b0;
         if (PHE_VALID) r_phe_prev <= PHE;
         if (!CAL_EN) begin
            // Disable wins over any concurrent lock/unlock event
            r_state <= S_IDLE;
            r_pm    <= '0;
            r_pe    <= '0;
            r_cnt   <= '0;
            PERR    <= '0;
            LOCK    <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: r_state <= S_ALIGN;
               S_ALIGN: begin
                  if (PHE_VALID) begin
                     r_pm    <= w_pm_next;
                     r_pe    <= w_pm_next;   // zero the error at alignment
                     PERR    <= '0;
                     r_cnt   <= '0;
                     r_state <= S_TRACK;
                  end
               end
               S_TRACK: begin
                  if (PHE_VALID) begin
                     r_pm       <= w_pm_next;
                     r_pe       <= w_pe_next;
                     PERR       <= w_perr;
                     r_perr_upd <= 1'b1;
                     if (w_in_win) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == c_CNT_LAST) begin
                           LOCK    <= 1'b1;
                           r_state <= S_LOCKED;
                        end
                     end else begin
                        r_cnt <= '0;
                     end
                  end
               end
               S_LOCKED: begin
                  if (PHE_VALID) begin
                     r_pm       <= w_pm_next;
                     r_pe       <= w_pe_next;
                     PERR       <= w_perr;
                     r_perr_upd <= 1'b1;
                     if (!w_in_win) begin
                        LOCK    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_TRACK;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // ---------------- sign-sign LMS on the DTC gain ----------------
   logic w_perr_pos, w_perr_neg, w_dcw_pos, w_dcw_neg, w_k_inc, w_k_dec;

   assign w_perr_pos = ~PERR[PW-1] & (PERR != '0);
   assign w_perr_neg = PERR[PW-1];
   assign w_dcw_pos  = r_dcw3 > c_DCW_MID;
   assign w_dcw_neg  = r_dcw3 < c_DCW_MID;
   assign w_k_inc    = (w_perr_pos & w_dcw_pos) | (w_perr_neg & w_dcw_neg);
   assign w_k_dec    = (w_perr_pos & w_dcw_neg) | (w_perr_neg & w_dcw_pos);

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         KDTC <= KW'(KDTC_INIT);
      end else if (r_perr_upd) begin
         if (w_k_inc && (KDTC != c_KMAX))     KDTC <= KDTC + 1'b1;
         else if (w_k_dec && (KDTC != '0))    KDTC <= KDTC - 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fod_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fod_phase_monitor
//  Purpose  : Directed self-checking bench for fod_phase_monitor: decode,
//             illegal codes, ideal tracking and lock, wrap-around, LMS gain
//             estimation, reset and enable behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fod_phase_monitor;

   localparam logic [21:0] c_FCW_425 = 22'd278528;   // 4.25 * 2^16
   localparam logic [21:0] c_FCW_423 = 22'd277217;   // 4.23 * 2^16 (truncated)

   logic        clk = 1'b0;
   logic        rst;
   logic        cal_en;
   logic [7:0]  psamp;
   logic [21:0] fcw;
   logic [9:0]  dcw;
   logic [2:0]  phe;
   logic        phe_valid, bub_err, lock;
   logic [7:0]  err_cnt;
   logic [11:0] perr;
   logic [9:0]  kdtc;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   fod_phase_monitor dut (
      .CLK(clk), .ARST(rst), .CAL_EN(cal_en), .PSAMP(psamp), .FCW_FOD(fcw),
      .DTC_DCW(dcw), .PHE(phe), .PHE_VALID(phe_valid), .BUB_ERR(bub_err),
      .ERR_CNT(err_cnt), .PERR(perr), .LOCK(lock), .KDTC(kdtc)
   );

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_chk++;
      if (obs == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
   endtask

   // Ring thermometer with its single 1->0 edge at phase p
   function automatic logic [7:0] pcode(input int p);
      logic [7:0] c;
      int         q;
      c = 8'd0;
      q = ((p % 8) + 8) % 8;
      for (int i = 0; i < 4; i++) c[(q - i + 8) % 8] = 1'b1;
      return c;
   endfunction

   // Drive at the falling edge; one rising edge then passes and outputs are
   // observed at the following falling edge.
   task automatic step(input logic [7:0] ps);
      psamp = ps;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic int sperr();
      return int'($signed(perr));
   endfunction

   initial begin
      int p, lock_step, max_abs, v, ka, kb, k_drop, s;
      longint acc;

      rst = 1'b1; cal_en = 1'b0; psamp = 8'h00; fcw = c_FCW_425; dcw = 10'd512;
      @(negedge clk);
      @(negedge clk);
      // ---- reset values ----
      chk("rst_phe", phe, 0);
      chk("rst_valid", phe_valid, 0);
      chk("rst_bub", bub_err, 0);
      chk("rst_errcnt", err_cnt, 0);
      chk("rst_perr", sperr(), 0);
      chk("rst_lock", lock, 0);
      chk("rst_kdtc", kdtc, 512);
      rst = 1'b0;

      // ---- 1: decode and latency ----
      step(8'b0000_0001);
      chk("dec_lat_valid", phe_valid, 0);
      step(8'b1000_0000);
      chk("dec_phe0", phe, 0);
      chk("dec_phe0_valid", phe_valid, 1);
      step(pcode(3));
      chk("dec_phe7", phe, 7);
      step(8'hFF);
      chk("dec_phe3", phe, 3);
      // ---- 2: illegal codes ----
      step(8'h00);
      chk("bub_ff_pulse", bub_err, 1);
      chk("bub_ff_hold", phe, 3);
      chk("bub_ff_valid", phe_valid, 0);
      chk("bub_ff_cnt", err_cnt, 1);
      step(8'b0101_0101);
      chk("bub_00_pulse", bub_err, 1);
      chk("bub_00_cnt", err_cnt, 2);
      step(pcode(3));
      chk("bub_55_pulse", bub_err, 1);
      chk("bub_55_hold", phe, 3);
      chk("bub_55_cnt", err_cnt, 3);
      step(pcode(3));
      chk("bub_clear", bub_err, 0);
      chk("bub_clear_valid", phe_valid, 1);
      for (int i = 0; i < 300; i++) step(8'h00);
      chk("errcnt_sat", err_cnt, 255);

      // ---- 3: ideal tracking and lock ----
      cal_en = 1'b1; fcw = c_FCW_425; dcw = 10'd512;
      do_reset();
      chk("trk_errcnt_rst", err_cnt, 0);
      p = 0; lock_step = 0; max_abs = 0;
      for (int k = 1; k <= 70; k++) begin
         step(pcode(p));
         p++;
         v = sperr();
         if (v < 0) v = -v;
         if (v > max_abs) max_abs = v;
         if (lock && lock_step == 0) lock_step = k;
      end
      chk("trk_lock_step", lock_step, 66);
      chk("trk_perr_zero", max_abs, 0);
      chk("trk_kdtc_hold", kdtc, 512);
      p = p + 3;                       // +3 phase jump
      step(pcode(p)); p++;
      step(pcode(p)); p++;
      chk("jump_lock_still", lock, 1);
      step(pcode(p)); p++;
      chk("jump_unlock", lock, 0);
      chk("jump_perr", sperr(), 1536);

      // ---- 4: wrap-around with non-integer phase step ----
      fcw = c_FCW_423;
      do_reset();
      acc = 0; max_abs = 0;
      for (int k = 0; k < 2000; k++) begin
         step(pcode(int'((acc >> 16) & 64'd7)));
         acc = acc + 4 * longint'(c_FCW_423);
         v = sperr();
         if (v < 0) v = -v;
         if (v > max_abs) max_abs = v;
      end
      chk("wrap_perr_bound", int'(max_abs <= 512), 1);
      chk("wrap_perr_nonzero", int'(max_abs > 0), 1);
      chk("wrap_no_bub", err_cnt, 0);

      // ---- 5: LMS ----
      fcw = c_FCW_425; dcw = 10'd800;
      do_reset();
      p = 0;
      for (int k = 0; k < 10; k++) begin step(pcode(p)); p++; end
      chk("lms_zero_err", kdtc, 512);
      p = p + 1;                       // constant +1 phase error from here on
      ka = 0; kb = 0;
      for (int j = 1; j <= 600; j++) begin
         step(pcode(p)); p++;
         if (j == 60) begin ka = kdtc; chk("lms_perr_pos", sperr(), 512); end
         if (j == 70) kb = kdtc;
      end
      chk("lms_inc_rate", kb - ka, 10);
      chk("lms_sat_hi", kdtc, 1023);
      dcw = 10'd200;
      for (int j = 0; j < 10; j++) begin step(pcode(p)); p++; end
      ka = kdtc;
      for (int j = 0; j < 100; j++) begin step(pcode(p)); p++; end
      kb = kdtc;
      chk("lms_dec_rate", ka - kb, 100);
      dcw = 10'd512;
      for (int j = 0; j < 10; j++) begin step(pcode(p)); p++; end
      ka = kdtc;
      for (int j = 0; j < 50; j++) begin step(pcode(p)); p++; end
      chk("lms_mid_hold", kdtc - ka, 0);

      // ---- 6: enable drop with positive error, then relock and reset ----
      dcw = 10'd800;
      for (int j = 0; j < 5; j++) begin step(pcode(p)); p++; end
      cal_en = 1'b0;
      step(pcode(p)); p++;
      chk("dis_perr", sperr(), 0);
      chk("dis_lock", lock, 0);
      step(pcode(p)); p++;
      k_drop = kdtc;
      for (int j = 0; j < 20; j++) begin step(pcode(p)); p++; end
      chk("dis_kdtc_hold", kdtc - k_drop, 0);
      chk("dis_perr_idle", sperr(), 0);
      cal_en = 1'b1; dcw = 10'd512;
      for (int j = 0; j < 80; j++) begin step(pcode(p)); p++; end
      chk("relock", lock, 1);
      chk("relock_perr", sperr(), 0);
      chk("relock_kdtc_moved", int'(kdtc != 10'd512), 1);
      s = 0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_phe", phe, 0);
      chk("arst_valid", phe_valid, 0);
      chk("arst_bub", bub_err, 0);
      chk("arst_errcnt", err_cnt, 0);
      chk("arst_perr", sperr(), 0);
      chk("arst_lock", lock, s);
      chk("arst_kdtc", kdtc, 512);
      @(negedge clk);
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
